// File: rtl/sdu_pkg.sv
// Shared definitions for the SDUltrasound transmit and receive blocks.
package sdu_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StPlay   = 2'd1,
        StListen = 2'd2,
        StGap    = 2'd3
    } sdu_state_e;

    localparam int unsigned SduGapCyclesDefault = 4;
    localparam int unsigned SduSampleW          = 16;

endpackage

// File: rtl/sdu_tx_if.sv
// Host/control bundle between the PC-side loader and the sdu_tx sequencer.
interface sdu_tx_if;
    logic [15:0] sdu_tx_data;
    logic        sdu_tx_strobe;
    logic        sdu_tx_clear;
    logic        sdu_tx_start;
    logic [15:0] sdu_num_seq;
    logic [31:0] sdu_listen_len;
    logic [15:0] dac_out;
    logic        sdu_tx_busy;
    logic        sdu_tx_overflow;
    logic        sdu_rx_en;
    logic        sdu_seq_done_strobe;
    logic        sdu_ave_done_strobe;

    modport master (
        output sdu_tx_data, sdu_tx_strobe, sdu_tx_clear, sdu_tx_start,
        output sdu_num_seq, sdu_listen_len,
        input  dac_out, sdu_tx_busy, sdu_tx_overflow, sdu_rx_en,
        input  sdu_seq_done_strobe, sdu_ave_done_strobe
    );

    modport slave (
        input  sdu_tx_data, sdu_tx_strobe, sdu_tx_clear, sdu_tx_start,
        input  sdu_num_seq, sdu_listen_len,
        output dac_out, sdu_tx_busy, sdu_tx_overflow, sdu_rx_en,
        output sdu_seq_done_strobe, sdu_ave_done_strobe
    );
endinterface

// File: rtl/inferred_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
module inferred_ram #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned AWIDTH = 16
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [DWIDTH-1:0] rdata_o
);

    logic [DWIDTH-1:0] mem_q [2**AWIDTH];
    logic [DWIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sdu_tx.sv
// Transmit sequencer: loads a waveform, then plays / listens / gaps num_seq times.
// Optional SDU_TX_TRSW_EN adds the sdu_tx_inh T/R switch output.
module sdu_tx
    import sdu_pkg::*;
#(
    parameter int unsigned AWIDTH     = 16,
    parameter int unsigned GAP_CYCLES = SduGapCyclesDefault
) (
    input  logic     clk,
    input  logic     reset,
    sdu_tx_if.slave  bus
`ifdef SDU_TX_TRSW_EN
    ,
    output logic     sdu_tx_inh
`endif
);

    localparam int unsigned GapW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [AWIDTH:0] Depth = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] LenOne = (AWIDTH+1)'(1);
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

    sdu_state_e        state_q, state_d;
    logic [AWIDTH:0]   wr_len_q, wr_len_d;
    logic [AWIDTH-1:0] rd_idx_q, rd_idx_d;
    logic [15:0]       seq_cnt_q, seq_cnt_d;
    logic [15:0]       num_seq_q, num_seq_d;
    logic [31:0]       listen_len_q, listen_len_d;
    logic [31:0]       lis_cnt_q, lis_cnt_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       dac_out_q, dac_out_d;

    logic              ram_we;
    logic [15:0]       ram_rdata;
    logic              wr_full;
    logic              play_last;
    logic              lis_last;
    logic              last_seq;
    logic              start_ok;

    assign wr_full   = (wr_len_q == Depth);
    assign play_last = ({1'b0, rd_idx_q} == (wr_len_q - LenOne));
    assign lis_last  = (lis_cnt_q == (listen_len_q - 32'd1));
    assign last_seq  = (seq_cnt_q == (num_seq_q - 16'd1));
    // A simultaneous clear empties the RAM, so a start in that cycle is refused.
    assign start_ok  = bus.sdu_tx_start && !bus.sdu_tx_clear &&
                       (wr_len_q != '0) && (bus.sdu_num_seq != 16'd0);

    always_comb begin
        state_d      = state_q;
        wr_len_d     = wr_len_q;
        rd_idx_d     = rd_idx_q;
        seq_cnt_d    = seq_cnt_q;
        num_seq_d    = num_seq_q;
        listen_len_d = listen_len_q;
        lis_cnt_d    = lis_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        overflow_d   = overflow_q;
        ram_we       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.sdu_tx_clear) begin
                    wr_len_d = '0;
                end else if (bus.sdu_tx_strobe) begin
                    if (wr_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        ram_we   = 1'b1;
                        wr_len_d = wr_len_q + LenOne;
                    end
                end
                if (start_ok) begin
                    num_seq_d    = bus.sdu_num_seq;
                    listen_len_d = bus.sdu_listen_len;
                    seq_cnt_d    = 16'd0;
                    rd_idx_d     = '0;
                    overflow_d   = 1'b0;
                    state_d      = StPlay;
                end
            end
            StPlay: begin
                if (play_last) begin
                    rd_idx_d  = '0;
                    lis_cnt_d = 32'd0;
                    gap_cnt_d = '0;
                    state_d   = (listen_len_q == 32'd0) ? StGap : StListen;
                end else begin
                    rd_idx_d = rd_idx_q + 1'b1;
                end
            end
            StListen: begin
                if (lis_last) begin
                    gap_cnt_d = '0;
                    state_d   = StGap;
                end else begin
                    lis_cnt_d = lis_cnt_q + 32'd1;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    seq_cnt_d = seq_cnt_q + 16'd1;
                    rd_idx_d  = '0;
                    state_d   = last_seq ? StIdle : StPlay;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle && bus.sdu_tx_strobe) begin
            overflow_d = 1'b1;
        end
    end

    // RAM is addressed with the next index so the sample is ready during its PLAY cycle.
    inferred_ram #(
        .DWIDTH (SduSampleW),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (wr_len_q[AWIDTH-1:0]),
        .wdata_i (bus.sdu_tx_data),
        .raddr_i (rd_idx_d),
        .rdata_o (ram_rdata)
    );

    assign dac_out_d = (state_q == StPlay) ? ram_rdata : 16'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            wr_len_q     <= '0;
            rd_idx_q     <= '0;
            seq_cnt_q    <= 16'd0;
            num_seq_q    <= 16'd0;
            listen_len_q <= 32'd0;
            lis_cnt_q    <= 32'd0;
            gap_cnt_q    <= '0;
            overflow_q   <= 1'b0;
            dac_out_q    <= 16'd0;
        end else begin
            state_q      <= state_d;
            wr_len_q     <= wr_len_d;
            rd_idx_q     <= rd_idx_d;
            seq_cnt_q    <= seq_cnt_d;
            num_seq_q    <= num_seq_d;
            listen_len_q <= listen_len_d;
            lis_cnt_q    <= lis_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            overflow_q   <= overflow_d;
            dac_out_q    <= dac_out_d;
        end
    end

    assign bus.dac_out             = dac_out_q;
    assign bus.sdu_tx_busy         = (state_q != StIdle);
    assign bus.sdu_tx_overflow     = overflow_q;
    assign bus.sdu_rx_en           = (state_q == StListen);
    assign bus.sdu_seq_done_strobe = (state_q == StListen) && lis_last && !last_seq;
    assign bus.sdu_ave_done_strobe = (state_q == StListen) && lis_last && last_seq;

`ifdef SDU_TX_TRSW_EN
    logic inh_q;

    // Same pipeline stage as dac_out, so the switch opens exactly around the burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            inh_q <= 1'b1;
        end else begin
            inh_q <= (state_q != StPlay);
        end
    end

    assign sdu_tx_inh = inh_q;
`endif

endmodule

// File: tb/tb_sdu_tx.sv
// Scoreboard bench for sdu_tx: stimulus pushes per-cycle expected outputs, a monitor pops them.
module tb_sdu_tx;

    localparam int Gap   = 4;
    localparam int Depth = 4;

    typedef struct packed {
        logic        busy;
        logic        rx;
        logic        sd;
        logic        ad;
        logic        ovf;
        logic        inh;
        logic [15:0] dac;
    } snap_t;

    logic clk;
    logic reset;
    logic inh_w;

    sdu_tx_if bus ();

    sdu_tx #(
        .AWIDTH     (2),
        .GAP_CYCLES (Gap)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef SDU_TX_TRSW_EN
        ,
        .sdu_tx_inh (inh_w)
`endif
    );

`ifndef SDU_TX_TRSW_EN
    assign inh_w = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    snap_t       exp_q [$];
    string       tag_q [$];
    logic [15:0] wave [$];
    logic        exp_ovf;
    int          checks;
    int          errors;

    always @(negedge clk) begin
        snap_t a;
        snap_t e;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a.busy = bus.sdu_tx_busy;
            a.rx   = bus.sdu_rx_en;
            a.sd   = bus.sdu_seq_done_strobe;
            a.ad   = bus.sdu_ave_done_strobe;
            a.ovf  = bus.sdu_tx_overflow;
            a.inh  = inh_w;
            a.dac  = bus.dac_out;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got busy=%b rx=%b sd=%b ad=%b ovf=%b inh=%b dac=%h, exp busy=%b rx=%b sd=%b ad=%b ovf=%b inh=%b dac=%h",
                         t, a.busy, a.rx, a.sd, a.ad, a.ovf, a.inh, a.dac,
                         e.busy, e.rx, e.sd, e.ad, e.ovf, e.inh, e.dac);
            end
        end
    end

    function automatic snap_t idle_snap();
        snap_t e;
        e = '0;
        e.ovf = exp_ovf;
`ifdef SDU_TX_TRSW_EN
        e.inh = 1'b1;
`endif
        return e;
    endfunction

    // Expected outputs c cycles after the start was presented, from the documented timing.
    function automatic snap_t model(int c, int len, int ll, int nseq, logic ovf0, int s_at, int r_at);
        snap_t e;
        int p_len;
        int rel;
        int p;
        e = '0;
        p_len = len + ll + Gap;
        if (r_at >= 0 && c > r_at) begin
`ifdef SDU_TX_TRSW_EN
            e.inh = 1'b1;
`endif
            return e;
        end
        e.ovf = (c == 0) ? ovf0 : ((s_at >= 0 && c > s_at) ? 1'b1 : 1'b0);
`ifdef SDU_TX_TRSW_EN
        e.inh = 1'b1;
`endif
        if (c >= 1 && c <= nseq * p_len) begin
            rel = c - 1;
            p = rel % p_len;
            e.busy = 1'b1;
            if (ll > 0 && p >= len && p < len + ll) e.rx = 1'b1;
            if (ll > 0 && p == len + ll - 1) begin
                if (rel / p_len == nseq - 1) e.ad = 1'b1;
                else e.sd = 1'b1;
            end
        end
        if (c >= 2) begin
            rel = c - 2;
            if (rel < nseq * p_len && (rel % p_len) < len) begin
                e.dac = wave[rel % p_len];
`ifdef SDU_TX_TRSW_EN
                e.inh = 1'b0;
`endif
            end
        end
        return e;
    endfunction

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s drain: got %0d pending entries, exp 0", name, exp_q.size());
            exp_q.delete();
            tag_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(idle_snap());
            tag_q.push_back($sformatf("%s idle%0d", name, i));
        end
        wait_drain(name);
    endtask

    task automatic load_one(input logic [15:0] d);
        bus.sdu_tx_data   = d;
        bus.sdu_tx_strobe = 1'b1;
        @(posedge clk);
        #1;
        bus.sdu_tx_strobe = 1'b0;
        if (wave.size() < Depth) wave.push_back(d);
        else exp_ovf = 1'b1;
    endtask

    task automatic clear_ram();
        bus.sdu_tx_clear = 1'b1;
        @(posedge clk);
        #1;
        bus.sdu_tx_clear = 1'b0;
        wave.delete();
    endtask

    task automatic load4(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
        load_one(a);
        load_one(b);
        load_one(c);
        load_one(d);
    endtask

    task automatic run(input string name, input int ll, input int nseq, input int s_at,
                       input int r_at);
        int len;
        int total;
        len = wave.size();
        total = nseq * (len + ll + Gap) + 2;
        bus.sdu_num_seq    = 16'(nseq);
        bus.sdu_listen_len = 32'(ll);
        bus.sdu_tx_start   = 1'b1;
        for (int c = 0; c < total; c++) begin
            exp_q.push_back(model(c, len, ll, nseq, exp_ovf, s_at, r_at));
            tag_q.push_back($sformatf("%s c%0d", name, c));
        end
        for (int c = 1; c < total; c++) begin
            @(posedge clk);
            #1;
            bus.sdu_tx_start  = 1'b0;
            bus.sdu_tx_strobe = (c == s_at);
            reset             = (c == r_at);
        end
        @(posedge clk);
        #1;
        bus.sdu_tx_strobe = 1'b0;
        reset = 1'b0;
        wait_drain(name);
        if (r_at >= 0) begin
            wave.delete();
            exp_ovf = 1'b0;
        end else begin
            exp_ovf = (s_at >= 0);
        end
    endtask

    task automatic bad_start(input string name, input int ll, input int nseq);
        bus.sdu_num_seq    = 16'(nseq);
        bus.sdu_listen_len = 32'(ll);
        bus.sdu_tx_start   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(idle_snap());
            tag_q.push_back($sformatf("%s c%0d", name, i));
        end
        @(posedge clk);
        #1;
        bus.sdu_tx_start = 1'b0;
        wait_drain(name);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_ovf = 1'b0;
        reset   = 1'b1;
        bus.sdu_tx_data    = 16'd0;
        bus.sdu_tx_strobe  = 1'b0;
        bus.sdu_tx_clear   = 1'b0;
        bus.sdu_tx_start   = 1'b0;
        bus.sdu_num_seq    = 16'd0;
        bus.sdu_listen_len = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        expect_idle("reset", 3);

        load4(16'd1, 16'hfffe, 16'd3, 16'hfffc);
        expect_idle("loaded", 2);
        run("basic", 5, 1, -1, -1);
        run("multi", 5, 3, -1, -1);
        run("busy_strobe", 3, 1, 3, -1);

        clear_ram();
        load4(16'd10, 16'd20, 16'd30, 16'd40);
        load_one(16'd50);
        expect_idle("full", 2);
        run("full_play", 2, 1, -1, -1);

        clear_ram();
        bad_start("no_wave", 5, 1);
        load_one(16'h0007);
        bad_start("no_seq", 5, 0);

        clear_ram();
        load4(16'd1, 16'hfffe, 16'd3, 16'hfffc);
        run("zero_listen", 0, 2, -1, -1);

        run("reset_listen", 5, 1, -1, 6);
        bad_start("post_reset", 5, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, exp finish");
        $fatal(1);
    end

endmodule
